// File: rtl/dram_axi_rd_slv_pkg.sv
// Shared types and constants for the DRAM AXI read slave: burst encodings,
// response codes, FSM state and the R-beat record carried through the output buffer.
package dram_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Default-width beat; the top re-declares the same layout at its own widths.
  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

endpackage

// File: rtl/dram_axi_rd_slv_if.sv
// Read-address and read-data channel bundle between the LSU (master) and the DRAM read slave.
interface dram_axi_rd_slv_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
);
  logic              lsu_axi_arvld;
  logic [ID_W-1:0]   lsu_axi_arid;
  logic [ADDR_W-1:0] lsu_axi_araddr;
  logic [7:0]        lsu_axi_arlen;
  logic [2:0]        lsu_axi_arsize;
  logic [1:0]        lsu_axi_arburst;
  logic [2:0]        lsu_axi_arstr;
  logic              axi_lsu_arrdy;
  logic              axi_lsu_rvld;
  logic              lsu_axi_rrdy;
  logic [ID_W-1:0]   axi_lsu_rid;
  logic [DATA_W-1:0] axi_lsu_rdata;
  logic [1:0]        axi_lsu_rresp;
  logic              axi_lsu_rlast;

  modport master (
    output lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen,
           lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr, lsu_axi_rrdy,
    input  axi_lsu_arrdy, axi_lsu_rvld, axi_lsu_rid, axi_lsu_rdata,
           axi_lsu_rresp, axi_lsu_rlast
  );

  modport slave (
    input  lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen,
           lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr, lsu_axi_rrdy,
    output axi_lsu_arrdy, axi_lsu_rvld, axi_lsu_rid, axi_lsu_rdata,
           axi_lsu_rresp, axi_lsu_rlast
  );
endinterface

// File: rtl/dram_axi_rd_slv_fifo.sv
// Two-entry R-beat buffer. The head is read straight from storage registers, so a
// push into an empty buffer becomes visible only in the following cycle.
module axi_rd_skid_fifo
  import dram_axi_pkg::*;
#(
  parameter type T = r_beat_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  T           din_i,
  input  logic       pop_i,
  output T           dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       do_pop;

  assign do_pop = pop_i && (cnt_q != 2'd0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (push_i && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= din_i;
      end
    end
  end

  // Issue is credit-limited upstream, so a push while full always coincides with a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dram_axi_rd_slv.sv
// AXI-style read slave over a 1-cycle-latency DRAM-model SRAM, stride-stepped bursts.
// Optional burst error checking is enabled by defining DRAM_AXI_RD_SLV_ERR_CHK_EN.
module dram_axi_rd_slv
  import dram_axi_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dram_axi_rd_slv_if.slave  axi,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        str_q;
  logic              fixed_q;
  logic              err_q;
  logic [8:0]        issued_q;
  logic [7:0]        beat_q;
  logic              infl_q;

  logic       ar_hs, issue, pop, ar_err;
  logic [2:0] credits_used;
  beat_t      push_beat, head;
  logic       fifo_full, fifo_empty;
  logic [1:0] fifo_cnt;
  logic       unused_ok;

`ifdef DRAM_AXI_RD_SLV_ERR_CHK_EN
  assign ar_err = (axi.lsu_axi_arsize != AXI_SIZE_8B) ||
                  (axi.lsu_axi_arburst == BURST_WRAP) ||
                  (axi.lsu_axi_arburst == BURST_RSVD);
  assign unused_ok = fifo_full;
`else
  assign ar_err    = 1'b0;
  assign unused_ok = ^{fifo_full, axi.lsu_axi_arsize};
`endif

  assign pop = axi.axi_lsu_rvld && axi.lsu_axi_rrdy;
  // A beat leaving this cycle frees its slot, keeping back-to-back issue under full rrdy.
  assign credits_used = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, pop};

  always_comb begin
    state_d = state_q;
    ar_hs   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axi.lsu_axi_arvld) begin
          ar_hs   = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        issue = (issued_q <= {1'b0, len_q}) && (credits_used < 3'd2);
        if (pop && head.last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      str_q    <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= '0;
      beat_q   <= '0;
      infl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue;
      if (ar_hs) begin
        id_q     <= axi.lsu_axi_arid;
        addr_q   <= axi.lsu_axi_araddr;
        len_q    <= axi.lsu_axi_arlen;
        str_q    <= axi.lsu_axi_arstr;
        fixed_q  <= (axi.lsu_axi_arburst == BURST_FIXED);
        err_q    <= ar_err;
        issued_q <= '0;
        beat_q   <= '0;
      end else begin
        if (issue) begin
          issued_q <= issued_q + 9'd1;
          if (!fixed_q) addr_q <= addr_q + ADDR_W'({1'b0, str_q} + 4'd1);
        end
        if (infl_q) beat_q <= beat_q + 8'd1;
      end
    end
  end

  // Error bursts keep the same pacing: infl_q stands in for the SRAM latency.
  assign mem_rd_en   = issue && !err_q;
  assign mem_rd_addr = addr_q;

  always_comb begin
    push_beat.id   = id_q;
    push_beat.data = err_q ? '0 : mem_rd_data;
    push_beat.resp = err_q ? RESP_SLVERR : RESP_OKAY;
    push_beat.last = (beat_q == len_q);
  end

  axi_rd_skid_fifo #(.T(beat_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .din_i   (push_beat),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign axi.axi_lsu_arrdy = (state_q == ST_IDLE);
  assign axi.axi_lsu_rvld  = !fifo_empty;
  assign axi.axi_lsu_rid   = head.id;
  assign axi.axi_lsu_rdata = head.data;
  assign axi.axi_lsu_rresp = head.resp;
  assign axi.axi_lsu_rlast = head.last;

endmodule

// File: tb/tb_dram_axi_rd_slv.sv
// Directed scoreboard bench for dram_axi_rd_slv with a behavioural 1-cycle SRAM model.
module tb_dram_axi_rd_slv;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [63:0] mem [1024];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = 0;
  int hs_len = 0;
  int n_iss  = 0;
  int n_pop  = 0;
  logic  first_pend = 1'b0;
  logic  chk_lat    = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  beat_t      exp_q[$];
  logic [9:0] exp_addr_q[$];

  dram_axi_rd_slv_if #(.ADDR_W(10), .DATA_W(64), .ID_W(8)) axi ();

  dram_axi_rd_slv #(.ADDR_W(10), .DATA_W(64), .ID_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi         (axi),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output-side monitor: address order, beat scoreboard, stall stability, latency.
  always @(negedge clk) begin
    beat_t got, e;
    int outst;
    if (!rst_n) begin
      n_iss      <= 0;
      n_pop      <= 0;
      prev_stall <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      got = {axi.axi_lsu_rid, axi.axi_lsu_rdata, axi.axi_lsu_rresp, axi.axi_lsu_rlast};
      if (axi.lsu_axi_arvld && axi.axi_lsu_arrdy) begin
        hs_cyc     <= cyc;
        hs_len     <= int'(axi.lsu_axi_arlen);
        first_pend <= 1'b1;
      end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("mem_rd_unexpected", 1, 0);
        else check("mem_rd_addr", mem_rd_addr, exp_addr_q.pop_front());
        outst = n_iss - n_pop + 1 - ((axi.axi_lsu_rvld && axi.lsu_axi_rrdy) ? 1 : 0);
        check("outstanding_le2", (outst <= 2), 1);
        n_iss <= n_iss + 1;
      end
      if (prev_stall) check("stall_hold", {axi.axi_lsu_rvld, got}, {1'b1, prev_beat});
      if (axi.axi_lsu_rvld && first_pend) begin
        check("first_rvld_lat", cyc - hs_cyc, 3);
        first_pend <= 1'b0;
      end
      if (axi.axi_lsu_rvld && axi.lsu_axi_rrdy) begin
        if (exp_q.size() == 0) check("rbeat_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rbeat", got, e);
        end
        if (!axi.axi_lsu_rlast) check("arrdy_in_burst", axi.axi_lsu_arrdy, 0);
        if (axi.axi_lsu_rlast && chk_lat) check("last_lat", cyc - hs_cyc, 3 + hs_len);
        n_pop <= n_pop + 1;
      end
      prev_stall <= axi.axi_lsu_rvld && !axi.lsu_axi_rrdy;
      prev_beat  <= got;
    end
  end

  task automatic send_ar(input int id, input int addr, input int len,
                         input int burst, input int str, input int size);
    int   a;
    logic err;
    beat_t b;
`ifdef DRAM_AXI_RD_SLV_ERR_CHK_EN
    err = (size != 3) || (burst >= 2);
`else
    err = 1'b0;
`endif
    a = addr;
    for (int k = 0; k <= len; k++) begin
      b.id   = 8'(id);
      b.data = err ? 64'd0 : mem[a];
      b.resp = err ? 2'd2 : 2'd0;
      b.last = (k == len);
      exp_q.push_back(b);
      if (!err) exp_addr_q.push_back(10'(a));
      if (burst != 0) a = (a + str + 1) % 1024;
    end
    check("arrdy_idle", axi.axi_lsu_arrdy, 1);
    axi.lsu_axi_arvld   = 1'b1;
    axi.lsu_axi_arid    = 8'(id);
    axi.lsu_axi_araddr  = 10'(addr);
    axi.lsu_axi_arlen   = 8'(len);
    axi.lsu_axi_arburst = 2'(burst);
    axi.lsu_axi_arstr   = 3'(str);
    axi.lsu_axi_arsize  = 3'(size);
    @(posedge clk);
    #1;
    axi.lsu_axi_arvld = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    check("burst_done_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check("arrdy_after", axi.axi_lsu_arrdy, 1);
    check("rvld_after", axi.axi_lsu_rvld, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arrdy"}, axi.axi_lsu_arrdy, 1);
    check({tag, "_rvld"}, axi.axi_lsu_rvld, 0);
    check({tag, "_rid"}, axi.axi_lsu_rid, 0);
    check({tag, "_rdata"}, axi.axi_lsu_rdata, 0);
    check({tag, "_rresp"}, axi.axi_lsu_rresp, 0);
    check({tag, "_rlast"}, axi.axi_lsu_rlast, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hBEEF, 16'(i), 32'(i * 32'h9E37 + 5)};
    mem_rd_data         = '0;
    axi.lsu_axi_arvld   = 1'b0;
    axi.lsu_axi_arid    = '0;
    axi.lsu_axi_araddr  = '0;
    axi.lsu_axi_arlen   = '0;
    axi.lsu_axi_arsize  = 3'd3;
    axi.lsu_axi_arburst = 2'd1;
    axi.lsu_axi_arstr   = '0;
    axi.lsu_axi_rrdy    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // INCR, back-to-back with rrdy held high
    chk_lat = 1'b1;
    send_ar(8'h11, 10, 3, 1, 0, 3);
    wait_done();

    // INCR with stride 2 wrapping past the top of memory
    send_ar(8'h22, 1022, 3, 1, 1, 3);
    wait_done();

    // FIXED burst re-reads the same word
    send_ar(8'h33, 5, 2, 0, 3, 3);
    wait_done();

    // rrdy toggling 1,0,0,1 under an 8-beat burst
    chk_lat = 1'b0;
    send_ar(8'h44, 40, 7, 1, 0, 3);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      axi.lsu_axi_rrdy = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clk);
      #1;
    end
    axi.lsu_axi_rrdy = 1'b1;
    wait_done();

    // WRAP burst: error burst when checking is built in, plain INCR otherwise
    chk_lat = 1'b1;
    send_ar(8'h5A, 77, 1, 2, 0, 3);
    wait_done();

    // Reset in the middle of a burst, after at least two beats
    send_ar(8'h55, 200, 7, 1, 0, 3);
    for (int i = 0; i < 100 && n_pop < 2; i++) @(posedge clk);
    check("reached_beat2", (n_pop >= 2), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arrdy_post_rst", axi.axi_lsu_arrdy, 1);
    send_ar(8'h66, 300, 3, 1, 2, 3);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_axi_rd_slv.md
# dram_axi_rd_slv

AXI-style read slave that services the LSU's DRAM read-address channel (`lsu_axi_ar*`) and returns read-data beats on `axi_lsu_r*`. It drives a single-port synchronous DRAM-model SRAM of 1024 × 64-bit words with 1-cycle read latency. Bursts are address-stepped by the LSU stride field and sustain one beat per cycle under `rrdy` backpressure through a 2-entry output buffer. It sits directly downstream of the LSU and feeds IRAM/WRAM loads.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; the SRAM depth is 2^ADDR_W.
- `DATA_W`, default 64: beat width.
- `ID_W`, default 8: transaction ID width.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lsu_axi_arvld`  in  1  read-address valid.
- `lsu_axi_arid`  in  ID_W  transaction ID.
- `lsu_axi_araddr`  in  ADDR_W  start word address (64-bit word index).
- `lsu_axi_arlen`  in  8  beat count minus 1.
- `lsu_axi_arsize`  in  3  beat size; only 3 (8 bytes) is legal.
- `lsu_axi_arburst`  in  2  0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- `lsu_axi_arstr`  in  3  INCR stride; word step = arstr + 1.
- `axi_lsu_arrdy`  out  1  read-address ready.
- `axi_lsu_rvld`  out  1  read-data valid.
- `lsu_axi_rrdy`  in  1  read-data ready.
- `axi_lsu_rid`  out  ID_W  echoed `arid`.
- `axi_lsu_rdata`  out  DATA_W  beat data.
- `axi_lsu_rresp`  out  2  0 = OKAY, 2 = SLVERR.
- `axi_lsu_rlast`  out  1  final beat of the burst.
- `mem_rd_en`  out  1  SRAM read strobe.
- `mem_rd_addr`  out  ADDR_W  SRAM word address.
- `mem_rd_data`  in  DATA_W  SRAM data, valid the cycle after `mem_rd_en`.

## Operation
- The FSM has two states, IDLE and BURST. `axi_lsu_arrdy` = (state == IDLE).
- IDLE → BURST on `arvld & arrdy`. The block latches `arid`, `araddr`, `arlen`, `arburst`, `arstr`, and the error flag, then clears the issue counter and the accept counter.
- In BURST, a read is issued (`mem_rd_en` = 1) when issued_cnt ≤ arlen and (buffer occupancy + reads in flight) < 2.
- Address update after each issue:
  - INCR: address += arstr + 1, modulo 2^ADDR_W (1023 + 1 wraps to 0).
  - FIXED: address is unchanged.
- Returned SRAM data is pushed into the 2-entry buffer along with rid, rresp, and rlast. rlast = (beat index == arlen).
- The buffer head drives the `r*` outputs. A pop happens on `rvld & rrdy`.
- BURST → IDLE on the handshake of the rlast beat. `arrdy` returns to 1 the next cycle.
- A burst always produces exactly arlen+1 beats (1..256), including error bursts.
- Simultaneous push and pop with the buffer full: this is legal only because issue is credit-limited. The pop happens first, so the buffer never overflows.
- The buffer is never pushed when empty-and-popping. A push into an empty buffer appears on the outputs in the following cycle, with no combinational bypass.
- `rdata`, `rid`, `rresp`, and `rlast` hold stable while `rvld & !rrdy`.
- Reset mid-burst: all state clears asynchronously and in-flight beats are discarded.

## Timing
- Reset values: `arrdy` = 1, `rvld` = 0, `rid` = 0, `rdata` = 0, `rresp` = 0, `rlast` = 0, `mem_rd_en` = 0, `mem_rd_addr` = 0.
- AR handshake in cycle T → first `mem_rd_en` in T+1 → first `rvld` in T+3 (SRAM +1, buffer register +1).
- With `rrdy` held high, beats are back-to-back, one per cycle. The last beat arrives at T+3+arlen.
- If `rrdy` drops, at most 2 beats are buffered and issue stalls the same cycle occupancy reaches 2.
- Earliest next AR handshake is the cycle after the rlast handshake.

## Configuration
- `DRAM_AXI_RD_SLV_ERR_CHK_EN` defined:
  - arsize != 3, arburst == 2, or arburst == 3 marks the burst as an error.
  - Every beat of an error burst returns rresp = SLVERR (2) and rdata = 0, and no SRAM reads are issued. Beat pacing stays identical, using a 1-cycle internal stand-in for the SRAM latency.
- `DRAM_AXI_RD_SLV_ERR_CHK_EN` undefined:
  - No checks are made, and all bursts other than FIXED are treated as INCR.
  - rresp is always OKAY.

## Structure
- Package `dram_axi_pkg` holds:
  - burst enum (FIXED/INCR/WRAP/RSVD);
  - resp constants (OKAY = 2'd0, SLVERR = 2'd2);
  - `AXI_SIZE_8B` = 3'd3;
  - the FSM state typedef;
  - a packed R-beat struct {id, data, resp, last}.
- Sub-module `axi_rd_skid_fifo`: a 2-entry FIFO of R-beat structs with push/pop, full/empty flags, and registered outputs.

## Test plan
- INCR, araddr = 10, arlen = 3, arstr = 0, rrdy = 1 → `mem_rd_addr` 10,11,12,13; 4 back-to-back beats with data = mem[10..13]; rlast on beat 4; first rvld at T+3.
- INCR, araddr = 1022, arlen = 3, arstr = 1 → addresses 1022, 0, 2, 4 (wrap).
- FIXED, araddr = 5, arlen = 2 → three beats, each carrying mem[5].
- INCR arlen = 7 with rrdy toggling 1,0,0,1,… → no beat lost or duplicated; outputs stable while stalled; at most 2 reads outstanding; exactly 8 beats, and arrdy = 0 until the rlast handshake.
- With `DRAM_AXI_RD_SLV_ERR_CHK_EN`: arburst = 2, arlen = 1 → 2 beats with rresp = 2 and rdata = 0, and `mem_rd_en` never asserted. Without the macro: 2 OKAY INCR beats.
- Assert rst_n = 0 mid-burst after beat 2 → all outputs go to their reset values immediately; arrdy = 1 after release; a new burst completes correctly.
